score_bcd_display: RTL



---
 rtl/display_pkg.sv | 59 +++++
 rtl/score_bcd_display_bin2bcd_seq.sv | 71 +++++++
 rtl/score_bcd_display.sv | 107 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the score display: converter FSM states,
// saturation limit and active-low seven-segment glyphs.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam logic [13:0] SAT_MAX      = 14'd9999;
  localparam logic [19:0] SAT_MAX_WIDE = 20'd9999;
  localparam logic [3:0]  LAST_ITER    = 4'd13;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] glyph;
    case (nib)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Double-dabble correction applied to all four nibbles before each shift
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = add3(bcd[i*4 +: 4]);
    end
    return adj;
  endfunction

endpackage

// File: rtl/score_bcd_display_bin2bcd_seq.sv
// Free-running 14-bit to 4-digit BCD converter: one capture cycle,
// fourteen shift-add-3 cycles and one result cycle, repeating forever.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  conv_state_t state_r;
  logic [15:0] scratch_r;
  logic [13:0] bin_r;
  logic [3:0]  iter_r;
  logic        done_r;
  logic [15:0] adj_s;
  logic [29:0] shifted_s;

  // Correct the scratch digits and shift the combined register by one bit
  always_comb begin
    adj_s     = bcd_adjust(scratch_r);
    shifted_s = {adj_s, bin_r} << 5'd1;
  end

  // Converter FSM; done is high exactly in the cycle scratch holds the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      scratch_r <= 16'h0000;
      bin_r     <= 14'd0;
      iter_r    <= 4'd0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bin_r     <= bin;
          scratch_r <= 16'h0000;
          iter_r    <= LAST_ITER;
          done_r    <= 1'b0;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          scratch_r <= shifted_s[29:14];
          bin_r     <= shifted_s[13:0];
          iter_r    <= iter_r - 4'd1;
          if (iter_r == 4'd0) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd  = scratch_r;
  assign done = done_r;

endmodule

// File: rtl/score_bcd_display.sv
// Four-digit multiplexed seven-segment driver for the score / high score,
// saturated to 9999 and shown in decimal with optional leading-zero blanking.
module score_bcd_display
  import display_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi,
  input  logic [19:0] score,
  input  logic [19:0] highest,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  logic [19:0] sel_s;
  logic [13:0] sat_s;
  logic [15:0] conv_bcd_s;
  logic        conv_done_s;
  logic [15:0] bcd_q_r;
  logic [REFRESH_BITS-1:0] refresh_r;
  logic [1:0]  digit_s;
  logic [3:0]  nib_s;
  logic        blank_s;
  logic [6:0]  glyph_s;
  logic        dp_s;
  logic [7:0]  seg_r;
  logic [3:0]  an_r;

  // Pick the value to show and clamp it to four decimal digits
  always_comb begin
    sel_s = hi ? highest : score;
    if (sel_s > SAT_MAX_WIDE) begin
      sat_s = SAT_MAX;
    end else begin
      sat_s = sel_s[13:0];
    end
  end

  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst  (rst),
    .bin  (sat_s),
    .bcd  (conv_bcd_s),
    .done (conv_done_s)
  );

  // Displayed value only ever takes complete conversion results
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q_r <= 16'h0000;
    end else if (conv_done_s) begin
      bcd_q_r <= conv_bcd_s;
    end else begin
      bcd_q_r <= bcd_q_r;
    end
  end

  // Select the active digit's nibble and decide whether it is a leading zero
  always_comb begin
    digit_s = refresh_r[REFRESH_BITS-1 -: 2];
    case (digit_s)
      2'd3: begin
        nib_s   = bcd_q_r[15:12];
        blank_s = BLANK_LZ && (bcd_q_r[15:12] == 4'd0);
      end
      2'd2: begin
        nib_s   = bcd_q_r[11:8];
        blank_s = BLANK_LZ && (bcd_q_r[15:8] == 8'd0);
      end
      2'd1: begin
        nib_s   = bcd_q_r[7:4];
        blank_s = BLANK_LZ && (bcd_q_r[15:4] == 12'd0);
      end
      2'd0: begin
        nib_s   = bcd_q_r[3:0];
        blank_s = 1'b0;
      end
      default: begin
        nib_s   = 4'd0;
        blank_s = 1'b1;
      end
    endcase
    glyph_s = blank_s ? SEG_BLANK : seg_decode(nib_s);
    // dp marks the high-score view and tracks the live hi input
    dp_s    = ~((digit_s == 2'd0) && hi);
  end

  // Refresh counter and registered digit/segment drive
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_r <= '0;
      seg_r     <= 8'hFF;
      an_r      <= 4'hF;
    end else begin
      refresh_r <= refresh_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      seg_r     <= {dp_s, glyph_s};
      an_r      <= ~(4'b0001 << digit_s);
    end
  end

  assign seg = seg_r;
  assign an  = an_r;

endmodule
